// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared MIPS datapath constants, types and the writeback select helper
package wb_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [DATA_W-1:0] dataT;
  typedef logic [REG_ADDR_W-1:0] regAddrT;
  function automatic dataT wbSel(input logic memtoReg, input dataT memData, input dataT aluData);
    return memtoReg ? memData : aluData;
  endfunction
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback/read bus between the pipeline (master) and the register file (slave)
//   writeback in : MemDataIn, ALUDataIn, WriteBackRegIn, RegWriteIn, MemtoRegIn
//   read in/out  : ReadReg1, ReadReg2 -> ReadData1, ReadData2
//   status out   : WriteDataOut (forwarding value), RetireCount
interface wb_regfile_if;
  import wb_regfile_pkg::*;
  dataT MemDataIn;
  dataT ALUDataIn;
  regAddrT WriteBackRegIn;
  logic RegWriteIn;
  logic MemtoRegIn;
  regAddrT ReadReg1;
  regAddrT ReadReg2;
  dataT ReadData1;
  dataT ReadData2;
  dataT WriteDataOut;
  dataT RetireCount;
  modport master(
    output MemDataIn, ALUDataIn, WriteBackRegIn, RegWriteIn, MemtoRegIn, ReadReg1, ReadReg2,
    input ReadData1, ReadData2, WriteDataOut, RetireCount
  );
  modport slave(
    input MemDataIn, ALUDataIn, WriteBackRegIn, RegWriteIn, MemtoRegIn, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteDataOut, RetireCount
  );
endinterface

// File: rtl/wb_regfile_core.sv
// regfile_core: 32x32 register storage with two combinational read ports, reg 0 hardwired to zero
//   clk, rst_n        : clock, synchronous active-low reset
//   we, wAddr, wData  : write port, takes effect on the rising edge
//   rAddrN -> rDataN  : combinational read ports
//   WB_BYPASS_EN      : when defined, a read of the register being written returns wData
module regfile_core
  import wb_regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we,
  input  regAddrT wAddr,
  input  dataT    wData,
  input  regAddrT rAddr1,
  input  regAddrT rAddr2,
  output dataT    rData1,
  output dataT    rData2
);
  dataT regs [NUM_REGS];
  logic byp1;
  logic byp2;
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we && wAddr != '0) regs[wAddr] <= wData;
`ifdef WB_BYPASS_EN
  assign byp1 = we && rst_n && rAddr1 == wAddr;
  assign byp2 = we && rst_n && rAddr2 == wAddr;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  // address 0 is masked first, so a pending write to reg 0 never bypasses
  always_comb begin
    rData1 = rAddr1 == '0 ? '0 : byp1 ? wData : regs[rAddr1];
    rData2 = rAddr2 == '0 ? '0 : byp2 ? wData : regs[rAddr2];
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage: writeback mux, register file and retired-write counter
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : wb_regfile_if.slave carrying writeback inputs, read ports, WriteDataOut, RetireCount
//   WB_BYPASS_EN (macro) enables same-cycle write-through on the read ports
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  wb_regfile_if.slave bus
);
  dataT retireCount;
  assign bus.WriteDataOut = wbSel(bus.MemtoRegIn, bus.MemDataIn, bus.ALUDataIn);
  assign bus.RetireCount = retireCount;
  always_ff @(posedge clk)
    if (!rst_n) retireCount <= '0;
    else if (bus.RegWriteIn) retireCount <= retireCount + 32'd1;
  regfile_core uCore (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.RegWriteIn),
    .wAddr  (bus.WriteBackRegIn),
    .wData  (bus.WriteDataOut),
    .rAddr1 (bus.ReadReg1),
    .rAddr2 (bus.ReadReg2),
    .rData1 (bus.ReadData1),
    .rData2 (bus.ReadData2)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed table, corner sequences and randomized model check of wb_regfile
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wb_regfile_if bus();
  wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mdl [32];
  logic [31:0] cnt = '0;

  typedef struct {
    bit r; logic [31:0] mem; logic [31:0] alu; logic [4:0] wr; bit we; bit m2r;
    logic [4:0] a1; logic [4:0] a2;
    logic [31:0] eWdo; logic [31:0] eRd1; logic [31:0] eRd2; logic [31:0] eRc;
  } vecT;
  vecT vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] wr,
                       input bit we, input bit m2r, input logic [4:0] a1, input logic [4:0] a2);
    rst_n = r;
    bus.MemDataIn = mem;
    bus.ALUDataIn = alu;
    bus.WriteBackRegIn = wr;
    bus.RegWriteIn = we;
    bus.MemtoRegIn = m2r;
    bus.ReadReg1 = a1;
    bus.ReadReg2 = a2;
    #1;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a);
    logic [31:0] w;
    w = bus.MemtoRegIn ? bus.MemDataIn : bus.ALUDataIn;
    if (a == 0) return 32'h0;
    if (BYP && rst_n && bus.RegWriteIn && a == bus.WriteBackRegIn) return w;
    return mdl[a];
  endfunction

  task automatic chkModel();
    chk("wdo", bus.WriteDataOut, bus.MemtoRegIn ? bus.MemDataIn : bus.ALUDataIn);
    chk("rd1", bus.ReadData1, expRead(bus.ReadReg1));
    chk("rd2", bus.ReadData2, expRead(bus.ReadReg2));
    chk("rc", bus.RetireCount, cnt);
  endtask

  task automatic advance();
    logic [31:0] w;
    w = bus.MemtoRegIn ? bus.MemDataIn : bus.ALUDataIn;
    @(posedge clk);
    if (!rst_n) begin
      foreach (mdl[i]) mdl[i] = '0;
      cnt = '0;
    end else if (bus.RegWriteIn) begin
      cnt = cnt + 1;
      if (bus.WriteBackRegIn != 0) mdl[bus.WriteBackRegIn] = w;
    end
    #1;
  endtask

  task automatic randStep(input bit allowRst);
    drive(allowRst ? ($urandom_range(15) != 0) : 1'b1, $urandom, $urandom, 5'($urandom),
          $urandom_range(3) != 0, 1'($urandom), 5'($urandom), 5'($urandom));
    chkModel();
    advance();
  endtask

  initial begin
    vt[0] = '{1, 32'hDEADBEEF, 32'h12345678, 5, 1, 1, 5, 0, 32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0};
    vt[1] = '{1, 32'h0, 32'h55, 5, 0, 0, 5, 5, 32'h55, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vt[2] = '{1, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 1};
    vt[3] = '{1, 32'h0, 32'h0, 0, 0, 0, 0, 5, 32'h0, 32'h0, 32'hDEADBEEF, 2};
    vt[4] = '{1, 32'h0, 32'h1, 7, 1, 0, 7, 7, 32'h1, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 2};
    vt[5] = '{1, 32'h2, 32'h9, 7, 1, 1, 7, 7, 32'h2, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 3};
    vt[6] = '{1, 32'h0, 32'h0, 7, 0, 0, 7, 7, 32'h0, 32'h2, 32'h2, 4};
    vt[7] = '{0, 32'h0, 32'hAA, 3, 1, 0, 3, 5, 32'hAA, 32'h0, 32'hDEADBEEF, 4};
    vt[8] = '{1, 32'h0, 32'h0, 3, 0, 0, 3, 5, 32'h0, 32'h0, 32'h0, 0};
    foreach (mdl[i]) mdl[i] = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    advance();
    for (int i = 0; i < 20; i++) randStep(1'b0);
    drive(0, 32'h1, 32'h2, 9, 1, 0, 9, 9);
    advance();
    advance();
    for (int a = 0; a < 32; a++) begin
      drive(1, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      chk("rst_rd1", bus.ReadData1, 32'h0);
      chk("rst_rd2", bus.ReadData2, 32'h0);
    end
    chk("rst_rc", bus.RetireCount, 32'h0);
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].r, vt[i].mem, vt[i].alu, vt[i].wr, vt[i].we, vt[i].m2r, vt[i].a1, vt[i].a2);
      chk($sformatf("vec%0d_wdo", i), bus.WriteDataOut, vt[i].eWdo);
      chk($sformatf("vec%0d_rd1", i), bus.ReadData1, vt[i].eRd1);
      chk($sformatf("vec%0d_rd2", i), bus.ReadData2, vt[i].eRd2);
      chk($sformatf("vec%0d_rc", i), bus.RetireCount, vt[i].eRc);
      advance();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    dut.retireCount <= 32'hFFFFFFFF;
    cnt = 32'hFFFFFFFF;
    #1;
    chk("preload_rc", bus.RetireCount, 32'hFFFFFFFF);
    advance();
    chk("hold_rc", bus.RetireCount, 32'hFFFFFFFF);
    drive(1, 0, 32'h77, 12, 1, 0, 12, 0);
    advance();
    drive(1, 0, 0, 0, 0, 0, 12, 0);
    chk("wrap_rc", bus.RetireCount, 32'h0);
    chk("wrap_rd", bus.ReadData1, 32'h77);
    for (int i = 0; i < 400; i++) randStep(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port MemDataIn, input, 32, load data from the MEM/WB register.
REQ-004 SHALL have port ALUDataIn, input, 32, ALU result from the MEM/WB register.
REQ-005 SHALL have port WriteBackRegIn, input, 5, destination register index.
REQ-006 SHALL have port RegWriteIn, input, 1, write enable for the current writeback.
REQ-007 SHALL have port MemtoRegIn, input, 1, selects load data (1) or ALU data (0).
REQ-008 SHALL have ports ReadReg1 and ReadReg2, input, 5 each, decode-stage read addresses.
REQ-009 SHALL have ports ReadData1 and ReadData2, output, 32 each, combinational read data.
REQ-010 SHALL have port WriteDataOut, output, 32, selected writeback value for the forwarding unit.
REQ-011 SHALL have port RetireCount, output, 32, count of writeback cycles with RegWriteIn=1.

Function
REQ-012 SHALL drive WriteDataOut = MemtoRegIn ? MemDataIn : ALUDataIn, combinationally, zero latency.
REQ-013 SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-014 SHALL write WriteDataOut into register[WriteBackRegIn] on a rising edge when rst_n=1, RegWriteIn=1 and WriteBackRegIn!=0; the new value is stored after that edge (1-cycle write latency).
REQ-015 SHALL return register[ReadRegN] on ReadDataN combinationally; ReadRegN=0 SHALL yield 0.
REQ-016 SHALL allow both read ports to address the same register, including the write target, in the same cycle.
REQ-017 SHALL increment RetireCount by 1 on each rising edge with rst_n=1 and RegWriteIn=1, including writes to register 0; 0xFFFFFFFF SHALL wrap to 0.
REQ-018 SHALL leave all registers and RetireCount unchanged when RegWriteIn=0.

Reset
REQ-019 SHALL, on a rising edge with rst_n=0, clear registers 1..31 and RetireCount to 0.
REQ-020 SHALL give reset priority over a simultaneous write; no write or increment occurs on that edge.
REQ-021 SHALL yield ReadData1/2 = 0 for every address from the first edge after reset asserts until the first write; WriteDataOut SHALL remain purely combinational during reset.

Configuration
REQ-022 SHALL support macro WB_BYPASS_EN.
REQ-023 With WB_BYPASS_EN defined, ReadDataN SHALL return WriteDataOut when RegWriteIn=1, rst_n=1, ReadRegN=WriteBackRegIn and ReadRegN!=0 (same-cycle write-through).
REQ-024 Without WB_BYPASS_EN, ReadDataN SHALL return the stored (pre-write) value in that case; the hazard unit must cover the gap.

Structure
REQ-025 SHALL take DATA_W=32, REG_ADDR_W=5 and NUM_REGS=32 from the shared MIPS constants package.
REQ-026 SHALL instantiate one sub-module regfile_core (storage, read ports and bypass); the writeback mux and RetireCount stay at the top level.

Verification
REQ-027 Reset: rst_n=0 for 2 cycles after arbitrary writes -> all ReadData = 0 and RetireCount = 0.
REQ-028 Mux and write: MemtoRegIn=1, MemDataIn=0xDEADBEEF, ALUDataIn=0x12345678, reg 5, RegWriteIn=1 -> WriteDataOut=0xDEADBEEF immediately; after the edge ReadReg1=5 -> 0xDEADBEEF; RetireCount=1.
REQ-029 Register 0: write 0xFFFFFFFF to reg 0 -> ReadData = 0; RetireCount still increments.
REQ-030 Same-cycle read of the write target: reg 7 holds 0x1, write 0x2 to reg 7, ReadReg1=ReadReg2=7 in the same cycle -> 0x2 with WB_BYPASS_EN, 0x1 without; 0x2 after the edge in both builds.
REQ-031 Reset versus write: rst_n=0 with RegWriteIn=1 to reg 3 and value 0xAA -> reg 3 reads 0 after the edge; RetireCount=0.
REQ-032 Wrap: force RetireCount to 0xFFFFFFFF (reach it via a hierarchical preload), then one write cycle -> RetireCount=0.
